load_store_unit: RTL

Multi-cycle load/store initiator between the CPU execute stage and the word-addressed data memory. Accepts one load or store per request over a valid/ready handshake. Performs byte/halfword/word loads with sign or zero extension, and sub-word stores via read-modify-write, because memory writes are whole-word only. Detects misaligned and illegal accesses without touching memory, and returns a single-cycle response.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_align.sv | 32 +++
 rtl/load_store_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and access legality check for the load/store unit
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_READ, S_STORE, S_RESP} state_e;
   function automatic logic access_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic legal;
      logic misaligned;
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (!we && (f3 == F3_BU || f3 == F3_HU));
      misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
      return !legal || misaligned;
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane select/extension and sub-word store merge
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);
   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [4:0]  st_sh;
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] mask;
   always_comb begin
      byte_sh = {off, 3'b000};
      half_sh = {off[1], 4'b0000};
      b = word[byte_sh +: 8];
      h = word[half_sh +: 16];
      load_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                  funct3 == F3_BU ? {24'd0, b} :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_HU ? {16'd0, h} : word;
      mask = funct3 == F3_B ? 32'h0000_00FF << byte_sh :
             funct3 == F3_H ? 32'h0000_FFFF << half_sh : '1;
      st_sh = funct3 == F3_H ? half_sh : byte_sh;
      store_data = (word & ~mask) | ((wdata << st_sh) & mask);
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store initiator with read-modify-write for sub-word stores
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_read_data
);
   state_e      state_q, state_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic        resp_valid_q, resp_valid_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] load_data;
   logic [31:0] store_data;

   lsu_align u_align (
      .word       (mem_read_data),
      .wdata      (wdata_q),
      .funct3     (f3_q),
      .off        (off_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   // Memory strobes and address are registered alongside the state so they line up with it
   always_comb begin
      state_d = state_q;
      f3_d = f3_q;
      off_d = off_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      resp_valid_d = 1'b0;
      mem_read_d = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d = '0;
      mem_wdata_d = '0;
      case (state_q)
         S_IDLE: if (req_valid) begin
            f3_d = req_funct3;
            off_d = req_addr[1:0];
            wdata_d = req_wdata;
            rdata_d = '0;
            fault_d = access_fault(req_we, req_funct3, req_addr[1:0]);
            if (fault_d) begin
               state_d = S_RESP;
               resp_valid_d = 1'b1;
            end else begin
               state_d = !req_we ? S_LOAD : req_funct3 == F3_W ? S_STORE : S_RMW_READ;
               mem_read_d = state_d != S_STORE;
               mem_write_d = state_d == S_STORE;
               mem_addr_d = {req_addr[31:2], 2'b00};
               mem_wdata_d = mem_write_d ? req_wdata : '0;
            end
         end
         S_LOAD: begin
            rdata_d = load_data;
            state_d = S_RESP;
            resp_valid_d = 1'b1;
         end
         S_RMW_READ: begin
            state_d = S_STORE;
            mem_write_d = 1'b1;
            mem_addr_d = mem_addr_q;
            mem_wdata_d = store_data;
         end
         S_STORE: begin
            state_d = S_RESP;
            resp_valid_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         f3_q <= '0;
         off_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         resp_valid_q <= 1'b0;
         mem_read_q <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         f3_q <= f3_d;
         off_q <= off_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         resp_valid_q <= resp_valid_d;
         mem_read_q <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready = state_q == S_IDLE;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_fault = fault_q;
   assign mem_read = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr = mem_addr_q;
   assign mem_write_data = mem_wdata_q;
endmodule
